// File: rtl/adc_pkg.sv
// Shared types for the ADC averaging and hysteresis filter.
// Holds the comparator FSM state encoding and the default sample width.
package adc_pkg;

    localparam int ADC_DATA_W = 12;

    typedef enum logic [1:0] {
        WARMUP,
        LOW,
        HIGH
    } adc_state_t;

endpackage

// File: rtl/adc_window_avg.sv
// 4-sample sliding window with a running sum.
// avg_next is the average the window will hold once the current sample lands.
module adc_window_avg
    import adc_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [DATA_W-1:0] avg_next
);

    localparam int SW = DATA_W + 2;

    logic [DATA_W-1:0] win [4];
    logic [SW-1:0]     sum;
    logic [SW-1:0]     sum_next;

    // Never underflows: the oldest entry is always part of sum.
    assign sum_next = sum + SW'(sample_data) - SW'(win[3]);
    assign avg_next = DATA_W'(sum_next >> 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                win[i] <= '0;
            end
            sum <= '0;
        end else if (sample_valid) begin
            win[0] <= sample_data;
            win[1] <= win[0];
            win[2] <= win[1];
            win[3] <= win[2];
            sum    <= sum_next;
        end
    end

endmodule

// File: rtl/adc_hyst_filter.sv
// Moving-average ADC filter with debounced hysteresis comparison.
// Averages are only published once the window has filled after reset.
module adc_hyst_filter
    import adc_pkg::*;
#(
    parameter int DATA_W  = ADC_DATA_W,
    parameter int CONFIRM = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] thresh_hi,
    input  logic [DATA_W-1:0] thresh_lo,
    output logic              avg_valid,
    output logic [DATA_W-1:0] avg_data,
    output logic              comparison_result,
    output logic              crossing_pulse,
    output logic [7:0]        sample_count
);

    localparam logic [3:0] CONF = 4'(CONFIRM);

    adc_state_t        state_q;
    adc_state_t        state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              cross_d;
    logic              qualify;
    logic              load;
    logic [DATA_W-1:0] avg_next;

    adc_window_avg #(
        .DATA_W(DATA_W)
    ) u_win (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .avg_next    (avg_next)
    );

    // sample_count only reaches 3 inside WARMUP on the 4th sample.
    assign load = sample_valid &&
                  (state_q != WARMUP || sample_count == 8'd3);

    assign comparison_result = (state_q == HIGH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cross_d = 1'b0;
        qualify = 1'b0;
        unique case (state_q)
            WARMUP: begin
                if (load) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                qualify = avg_data > thresh_hi;
            end
            HIGH: begin
                qualify = avg_data < thresh_lo;
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
        if (avg_valid && state_q != WARMUP) begin
            if (!qualify) begin
                cnt_d = '0;
            end else if (cnt_q + 4'd1 == CONF) begin
                cnt_d   = '0;
                cross_d = 1'b1;
                state_d = (state_q == LOW) ? HIGH : LOW;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= WARMUP;
            cnt_q          <= '0;
            crossing_pulse <= 1'b0;
            avg_valid      <= 1'b0;
            avg_data       <= '0;
            sample_count   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            crossing_pulse <= cross_d;
            avg_valid      <= load;
            if (load) begin
                avg_data <= avg_next;
            end
            if (sample_valid) begin
                sample_count <= sample_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_adc_hyst_filter.sv
// Self-checking bench for adc_hyst_filter: directed vectors plus
// randomized traffic compared against a queue-based reference model.
module tb_adc_hyst_filter;

    localparam int DW   = 12;
    localparam int CONF = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic [DW-1:0] thresh_hi = 12'h800;
    logic [DW-1:0] thresh_lo = 12'h700;
    logic          avg_valid;
    logic [DW-1:0] avg_data;
    logic          comparison_result;
    logic          crossing_pulse;
    logic [7:0]    sample_count;

    int n_checks = 0;
    int n_fail   = 0;

    int win_q[$];
    int m_nacc, m_avg, m_cnt, m_count;
    bit m_av, m_high, m_cross;

    adc_hyst_filter #(
        .DATA_W (DW),
        .CONFIRM(CONF)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sample_valid     (sample_valid),
        .sample_data      (sample_data),
        .thresh_hi        (thresh_hi),
        .thresh_lo        (thresh_lo),
        .avg_valid        (avg_valid),
        .avg_data         (avg_data),
        .comparison_result(comparison_result),
        .crossing_pulse   (crossing_pulse),
        .sample_count     (sample_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what should be visible right after one rising edge.
    task automatic model_edge(bit rst, bit v, int d);
        int s;
        bit qual;
        if (rst) begin
            win_q.delete();
            m_nacc  = 0;
            m_av    = 0;
            m_avg   = 0;
            m_cnt   = 0;
            m_count = 0;
            m_high  = 0;
            m_cross = 0;
        end else begin
            m_cross = 0;
            if (m_av) begin
                qual = m_high ? (m_avg < int'(thresh_lo))
                              : (m_avg > int'(thresh_hi));
                if (qual) begin
                    m_cnt++;
                    if (m_cnt == CONF) begin
                        m_high  = !m_high;
                        m_cnt   = 0;
                        m_cross = 1;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
            m_av = v && (m_nacc >= 3);
            if (v) begin
                win_q.push_front(d);
                if (win_q.size() > 4) void'(win_q.pop_back());
                m_nacc++;
                m_count = (m_count + 1) % 256;
                if (m_av) begin
                    s = 0;
                    foreach (win_q[i]) s += win_q[i];
                    m_avg = s / 4;
                end
            end
        end
    endtask

    task automatic step(bit rst, bit v, int d);
        reset        = rst;
        sample_valid = v;
        sample_data  = DW'(d);
        @(posedge clk);
        model_edge(rst, v, d);
        #1;
        chk("avg_valid", avg_valid, m_av);
        chk("avg_data", avg_data, m_avg);
        chk("comparison_result", comparison_result, m_high);
        chk("crossing_pulse", crossing_pulse, m_cross);
        chk("sample_count", sample_count, m_count);
    endtask

    initial begin
        int level, d;
        bit seen_av;

        step(1, 0, 0);
        step(1, 1, 12'h123);
        chk("reset_avg_valid", avg_valid, 0);
        chk("reset_count", sample_count, 0);

        // Warm-up: three samples give nothing, the 4th publishes
        seen_av = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 12'h100);
            seen_av |= avg_valid;
            step(0, 0, 0);
            seen_av |= avg_valid;
        end
        chk("warmup_no_avg", seen_av, 0);
        step(0, 1, 12'h100);
        chk("first_avg_valid", avg_valid, 1);
        chk("first_avg", avg_data, 12'h100);
        step(0, 0, 0);
        chk("first_result", comparison_result, 0);

        // Ramp average
        step(1, 0, 0);
        step(0, 1, 12'h100);
        step(0, 1, 12'h200);
        step(0, 1, 12'h300);
        step(0, 1, 12'h400);
        chk("ramp_avg", avg_data, 12'h280);

        // Step up to full scale and cross to HIGH
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 12'h100);
        step(0, 1, 12'hFFF);
        chk("up_avg1", avg_data, 12'h4BF);
        step(0, 1, 12'hFFF);
        chk("up_avg2", avg_data, 12'h87F);
        step(0, 1, 12'hFFF);
        chk("up_avg3", avg_data, 12'hC3F);
        step(0, 1, 12'hFFF);
        chk("up_avg4", avg_data, 12'hFFF);
        chk("up_not_yet", comparison_result, 0);
        step(0, 0, 0);
        chk("up_cross", crossing_pulse, 1);
        chk("up_result", comparison_result, 1);
        step(0, 0, 0);
        chk("up_cross_one_cycle", crossing_pulse, 0);

        // Reset while HIGH, with a concurrent sample that must be dropped
        step(1, 1, 12'hFFF);
        chk("hi_reset_result", comparison_result, 0);
        chk("hi_reset_avg", avg_data, 0);
        chk("hi_reset_count", sample_count, 0);
        seen_av = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 12'hFFF);
            seen_av |= avg_valid;
        end
        step(0, 0, 0);
        chk("hi_reset_no_avg", seen_av, 0);

        // Average exactly at thresh_hi clears the confirm counter
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 12'h900);
        step(0, 1, 12'h900);
        step(0, 1, 12'h500);
        chk("eq_avg", avg_data, 12'h800);
        step(0, 1, 12'h900);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("eq_no_cross", comparison_result, 0);

        // Randomized traffic with moving thresholds and rare resets
        level = 12'h800;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) level = $urandom_range(0, 4095);
            if (c % 150 == 0) begin
                thresh_hi = DW'($urandom_range(12'h500, 12'hB00));
                thresh_lo = DW'($urandom_range(12'h400, 12'hA00));
            end
            d = level + $urandom_range(0, 12'h400) - 12'h200;
            if (d < 0) d = 0;
            if (d > 4095) d = 4095;
            step($urandom_range(0, 399) == 0, $urandom_range(0, 9) < 6, d);
        end

        // Counter wrap
        thresh_hi = 12'h800;
        thresh_lo = 12'h700;
        step(1, 0, 0);
        for (int i = 0; i < 256; i++) step(0, 1, $urandom_range(0, 4095));
        chk("count_wrap", sample_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_hyst_filter.md
ADC_HYST_FILTER -- requirements
Module: adc_hyst_filter

Interface
REQ-001 Parameter DATA_W, default 12: width of ADC samples, thresholds and average.
REQ-002 Parameter CONFIRM, default 3: consecutive qualifying averages needed to change comparison state (range 1..15).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port sample_valid  input  1  one-cycle strobe, new ADC sample from the SPI control unit.
REQ-006 Port sample_data  input  DATA_W  unsigned ADC sample, valid only with sample_valid.
REQ-007 Port thresh_hi  input  DATA_W  upper threshold, unsigned.
REQ-008 Port thresh_lo  input  DATA_W  lower threshold, unsigned.
REQ-009 Port avg_valid  output  1  one-cycle strobe, new average available.
REQ-010 Port avg_data  output  DATA_W  4-sample moving average, held between strobes.
REQ-011 Port comparison_result  output  1  debounced hysteresis state, 1 = HIGH.
REQ-012 Port crossing_pulse  output  1  one-cycle pulse on every comparison_result change.
REQ-013 Port sample_count  output  8  accepted-sample counter.

Function
REQ-014 Each sample_valid cycle shall shift sample_data into a 4-entry window and update a DATA_W+2-bit running sum: sum + new - oldest.
REQ-015 avg_data shall equal the window sum right-shifted by 2 (truncating), registered; latency from sample_valid to avg_valid shall be exactly 1 cycle.
REQ-016 FSM states WARMUP, LOW, HIGH; reset enters WARMUP.
REQ-017 In WARMUP, avg_valid shall stay 0 until the 4th sample after reset; the cycle after the 4th sample, avg_valid shall pulse and the FSM shall enter LOW.
REQ-018 In LOW, each avg_valid with avg_data > thresh_hi shall increment the confirm counter; avg_data <= thresh_hi shall clear it.
REQ-019 In HIGH, each avg_valid with avg_data < thresh_lo shall increment the confirm counter; avg_data >= thresh_lo shall clear it.
REQ-020 When the counter reaches CONFIRM, the FSM shall switch state and clear the counter; comparison_result and crossing_pulse shall update the cycle after that avg_valid.
REQ-021 Cycles without avg_valid shall leave the confirm counter unchanged.
REQ-022 Thresholds shall be sampled at each evaluation; no ordering check between thresh_lo and thresh_hi.
REQ-023 The 4th warm-up average shall itself be evaluated in LOW (counts toward CONFIRM).
REQ-024 sample_count shall increment on each sample_valid and wrap 255 -> 0.
REQ-025 sample_valid asserted together with reset shall be ignored.

Reset
REQ-026 Reset shall clear window, sum, confirm counter, sample_count, avg_data, avg_valid, comparison_result, crossing_pulse to 0 and FSM to WARMUP, including mid-operation in HIGH.

Structure
REQ-027 Package adc_pkg shall hold the FSM state enum (WARMUP, LOW, HIGH) and default DATA_W.
REQ-028 The window plus running sum shall be one sub-module, adc_window_avg; FSM and counters in the top.

Verification (DATA_W=12, CONFIRM=3, thresh_hi=0x800, thresh_lo=0x700)
REQ-029 Reset, 3 samples of 0x100 -> avg_valid never asserted; 4th sample -> avg_valid next cycle, avg_data=0x100, comparison_result=0.
REQ-030 Samples 0x100,0x200,0x300,0x400 -> avg_data=0x280.
REQ-031 After 4x0x100, four 0xFFF -> avgs 0x4BF,0x87F,0xC3F,0xFFF; comparison_result=1 and crossing_pulse one cycle after 4th avg_valid.
REQ-032 Avgs 0x900,0x900,0x800 in LOW -> counter cleared, comparison_result stays 0; avg exactly 0x800 never counts.
REQ-033 In HIGH, assert reset one cycle -> all outputs 0, next 3 samples give no avg_valid.
REQ-034 256 samples after reset -> sample_count returns to 0.
